// File: rtl/rat_ckpt_pkg.sv
// Shared constants and helpers for the RAT checkpoint table.
package rat_ckpt_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH      = 128;
  localparam int DEF_PAGES      = 8;
  localparam int DEF_RESET_BASE = 32;

  // Outcome of a save request in the cycle it is presented.
  typedef enum logic [1:0] {
    SAVE_NONE    = 2'd0,  // no save requested
    SAVE_ACCEPT  = 2'd1,  // page allocated, snapshot taken
    SAVE_BLOCKED = 2'd2,  // restore has priority, silently dropped
    SAVE_FULL    = 2'd3   // no free page, reported through err
  } save_st_e;

  // Width of a page identifier; never narrower than one bit.
  function automatic int page_id_w(input int pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

endpackage

// File: rtl/rat_ckpt_table_if.sv
// Request/response bundle of the RAT checkpoint table.
interface rat_ckpt_table_if
  import rat_ckpt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PAGES  = DEF_PAGES
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = page_id_w(PAGES);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              save_req;
  logic              save_ack;
  logic [PW-1:0]     save_page;
  logic              restore_req;
  logic [PW-1:0]     restore_page;
  logic              release_req;
  logic [PW-1:0]     release_page;
  logic              pages_full;
  logic [PW:0]       pages_free;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    output save_req, restore_req, restore_page, release_req, release_page,
    input  rd_data, save_ack, save_page, pages_full, pages_free, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    input  save_req, restore_req, restore_page, release_req, release_page,
    output rd_data, save_ack, save_page, pages_full, pages_free, err
  );

endinterface

// File: rtl/rat_ckpt_page_alloc.sv
// Checkpoint page allocator: free bitmap, lowest-free pick and free count.
// Allocation always uses the bitmap registered at the start of the cycle,
// so a page freed this cycle can only be handed out from the next cycle.
module rat_ckpt_page_alloc
  import rat_ckpt_pkg::*;
#(
  parameter int PAGES = DEF_PAGES,
  parameter int PW    = page_id_w(PAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic             free_a_en,
  input  logic [PW-1:0]    free_a_page,
  input  logic             free_b_en,
  input  logic [PW-1:0]    free_b_page,
  output logic [PAGES-1:0] free_map,
  output logic [PW-1:0]    lowest_free,
  output logic             any_free,
  output logic [PW:0]      pages_free,
  output logic             pages_full
);

  logic [PAGES-1:0] free_map_r;
  logic [PW:0]      pages_free_r;
  logic             pages_full_r;
  logic [PW-1:0]    lowest_free_s;
  logic             any_free_s;
  logic [PAGES-1:0] alloc_mask_s;
  logic [PAGES-1:0] free_a_mask_s;
  logic [PAGES-1:0] free_b_mask_s;
  logic [PAGES-1:0] next_map_s;
  logic [PW:0]      next_cnt_s;

  localparam logic [PAGES-1:0] ONE_HOT0 = {{(PAGES-1){1'b0}}, 1'b1};

  function automatic logic [PW:0] popcount(input logic [PAGES-1:0] v);
    logic [PW:0] c;
    c = '0;
    for (int i = 0; i < PAGES; i++) begin
      c = c + {{PW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Lowest-index free page; scanning downward lets the lowest set bit win.
  always_comb begin
    lowest_free_s = '0;
    any_free_s    = |free_map_r;
    for (int i = PAGES - 1; i >= 0; i--) begin
      lowest_free_s = free_map_r[i] ? PW'(i) : lowest_free_s;
    end
  end

  // Next bitmap: clear the allocated page, set every freed page.
  always_comb begin
    alloc_mask_s  = alloc_en  ? (ONE_HOT0 << lowest_free_s) : '0;
    free_a_mask_s = free_a_en ? (ONE_HOT0 << free_a_page)   : '0;
    free_b_mask_s = free_b_en ? (ONE_HOT0 << free_b_page)   : '0;
    next_map_s    = (free_map_r & ~alloc_mask_s) | free_a_mask_s | free_b_mask_s;
    next_cnt_s    = popcount(next_map_s);
  end

  // Bitmap and occupancy status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_map_r   <= '1;
      pages_free_r <= (PW+1)'(PAGES);
      pages_full_r <= 1'b0;
    end else begin
      free_map_r   <= next_map_s;
      pages_free_r <= next_cnt_s;
      pages_full_r <= (next_cnt_s == '0);
    end
  end

  assign free_map    = free_map_r;
  assign lowest_free = lowest_free_s;
  assign any_free    = any_free_s;
  assign pages_free  = pages_free_r;
  assign pages_full  = pages_full_r;

endmodule

// File: rtl/rat_ckpt_table.sv
// Register alias table with whole-table checkpoint pages.
// A save copies the live table into the lowest free page; a restore copies
// a page back into the live table and frees it; a release just frees it.
module rat_ckpt_table
  import rat_ckpt_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PAGES      = DEF_PAGES,
  parameter int RESET_BASE = DEF_RESET_BASE
) (
  input  logic            clk,
  input  logic            reset,
  rat_ckpt_table_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = page_id_w(PAGES);

  logic [DATA_W-1:0] live_r [DEPTH];
  logic [DATA_W-1:0] page_r [PAGES][DEPTH];

  logic [PAGES-1:0]  free_map_s;
  logic [PW-1:0]     lowest_free_s;
  logic              any_free_s;
  logic [PW:0]       pages_free_s;
  logic              pages_full_s;

  save_st_e          save_st_s;
  logic              save_ok_s;
  logic              save_err_s;
  logic              restore_ok_s;
  logic              release_ok_s;
  logic              err_s;

  logic [DATA_W-1:0] rd_data_r;
  logic              save_ack_r;
  logic [PW-1:0]     save_page_r;
  logic              err_r;

  rat_ckpt_page_alloc #(
    .PAGES (PAGES),
    .PW    (PW)
  ) u_alloc (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (save_ok_s),
    .free_a_en   (restore_ok_s),
    .free_a_page (bus.restore_page),
    .free_b_en   (release_ok_s),
    .free_b_page (bus.release_page),
    .free_map    (free_map_s),
    .lowest_free (lowest_free_s),
    .any_free    (any_free_s),
    .pages_free  (pages_free_s),
    .pages_full  (pages_full_s)
  );

  // Classify this cycle's requests against the registered free bitmap.
  always_comb begin
    restore_ok_s = bus.restore_req & ~free_map_s[bus.restore_page];
    release_ok_s = bus.release_req & ~free_map_s[bus.release_page];
    save_ok_s    = 1'b0;
    save_err_s   = 1'b0;
    if (!bus.save_req) begin
      save_st_s = SAVE_NONE;
    end else if (bus.restore_req) begin
      save_st_s = SAVE_BLOCKED;
    end else if (any_free_s) begin
      save_st_s = SAVE_ACCEPT;
    end else begin
      save_st_s = SAVE_FULL;
    end
    case (save_st_s)
      SAVE_ACCEPT: begin
        save_ok_s  = 1'b1;
        save_err_s = 1'b0;
      end
      SAVE_FULL: begin
        save_ok_s  = 1'b0;
        save_err_s = 1'b1;
      end
      default: begin
        save_ok_s  = 1'b0;
        save_err_s = 1'b0;
      end
    endcase
    // A release of the page being restored is valid here, so it adds no err.
    err_s = save_err_s
          | (bus.restore_req & ~restore_ok_s)
          | (bus.release_req & ~release_ok_s);
  end

  // Registered read port and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r   <= '0;
      save_ack_r  <= 1'b0;
      save_page_r <= '0;
      err_r       <= 1'b0;
    end else begin
      rd_data_r   <= live_r[bus.rd_addr];
      save_ack_r  <= save_ok_s;
      save_page_r <= save_ok_s ? lowest_free_s : '0;
      err_r       <= err_s;
    end
  end

  // Live table: reset pattern, restore from a page, or a single write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_r[i] <= DATA_W'(RESET_BASE + i);
      end
    end else if (restore_ok_s) begin
      live_r <= page_r[bus.restore_page];
    end else if (bus.wr_en) begin
      live_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Page storage: snapshot of the pre-edge live table on an accepted save.
  always_ff @(posedge clk) begin
    if (reset && save_ok_s) begin
      page_r[lowest_free_s] <= live_r;
    end
  end

  assign bus.rd_data    = rd_data_r;
  assign bus.save_ack   = save_ack_r;
  assign bus.save_page  = save_page_r;
  assign bus.err        = err_r;
  assign bus.pages_free = pages_free_s;
  assign bus.pages_full = pages_full_s;

endmodule

// File: tb/tb_rat_ckpt_table.sv
// Directed scoreboard bench for rat_ckpt_table.
module tb_rat_ckpt_table;
  import rat_ckpt_pkg::*;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 128;
  localparam int PAGES      = 8;
  localparam int RESET_BASE = 32;
  localparam int AW         = $clog2(DEPTH);
  localparam int PW         = $clog2(PAGES);

  logic clk;
  logic reset;

  rat_ckpt_table_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PAGES(PAGES)) bus ();

  rat_ckpt_table #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PAGES(PAGES), .RESET_BASE(RESET_BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   m_live [DEPTH];
  int   m_page [PAGES][DEPTH];
  bit   m_free [PAGES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(bus.rd_data);
      1:       return 32'(bus.save_ack);
      2:       return 32'(bus.save_page);
      3:       return 32'(bus.err);
      4:       return 32'(bus.pages_free);
      5:       return 32'(bus.pages_full);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic void push(input string tag, input int sel, input int exp);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = exp;
    sb.push_back(x);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_live[i] = (RESET_BASE + i) % 256;
    for (int p = 0; p < PAGES; p++) m_free[p] = 1'b1;
  endtask

  task automatic idle();
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.rd_addr      = '0;
    bus.save_req     = 1'b0;
    bus.restore_req  = 1'b0;
    bus.restore_page = '0;
    bus.release_req  = 1'b0;
    bus.release_page = '0;
  endtask

  // One clock of stimulus: predict, push, clock, pop and compare.
  task automatic step(input string tag, input bit we, input int wa, input int wd,
                      input int ra, input bit sv, input bit rs, input int rp,
                      input bit rl, input int lp);
    int lowest;
    bit any, rok, lok, sok, e;
    int nfree;
    bus.wr_en        = we;
    bus.wr_addr      = AW'(wa);
    bus.wr_data      = DATA_W'(wd);
    bus.rd_addr      = AW'(ra);
    bus.save_req     = sv;
    bus.restore_req  = rs;
    bus.restore_page = PW'(rp);
    bus.release_req  = rl;
    bus.release_page = PW'(lp);
    any    = 1'b0;
    lowest = 0;
    for (int p = PAGES - 1; p >= 0; p--) begin
      if (m_free[p]) begin
        any    = 1'b1;
        lowest = p;
      end
    end
    rok = rs && !m_free[rp];
    lok = rl && !m_free[lp];
    sok = sv && !rs && any;
    e   = (sv && !rs && !any) || (rs && !rok) || (rl && !lok);
    push({tag, ".rd_data"}, 0, m_live[ra]);
    push({tag, ".save_ack"}, 1, int'(sok));
    push({tag, ".save_page"}, 2, sok ? lowest : 0);
    push({tag, ".err"}, 3, int'(e));
    if (sok) begin
      for (int d = 0; d < DEPTH; d++) m_page[lowest][d] = m_live[d];
      m_free[lowest] = 1'b0;
    end
    if (rok) begin
      for (int d = 0; d < DEPTH; d++) m_live[d] = m_page[rp][d];
      m_free[rp] = 1'b1;
    end else if (we) begin
      m_live[wa] = wd;
    end
    if (lok) m_free[lp] = 1'b1;
    nfree = 0;
    for (int p = 0; p < PAGES; p++) nfree += int'(m_free[p]);
    push({tag, ".pages_free"}, 4, nfree);
    push({tag, ".pages_full"}, 5, int'(nfree == 0));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk(x.tag, observe(x.sel), 32'(x.exp));
    end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    m_reset();
    #12;
    chk("rst.rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst.save_ack", 32'(bus.save_ack), 32'd0);
    chk("rst.save_page", 32'(bus.save_page), 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.pages_free", 32'(bus.pages_free), 32'd8);
    chk("rst.pages_full", 32'(bus.pages_full), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset contents of the live table.
    step("rd5", 0, 0, 0, 5, 0, 0, 0, 0, 0);
    chk("rd5.const", 32'(bus.rd_data), 32'd37);
    step("rd127", 0, 0, 0, 127, 0, 0, 0, 0, 0);
    chk("rd127.const", 32'(bus.rd_data), 32'd159);
    chk("rd127.free", 32'(bus.pages_free), 32'd8);

    // Save excludes the same-cycle write; restore brings the snapshot back.
    step("wr3", 1, 3, 8'hAA, 0, 0, 0, 0, 0, 0);
    step("save0", 1, 3, 8'h55, 3, 1, 0, 0, 0, 0);
    chk("save0.ack", 32'(bus.save_ack), 32'd1);
    chk("save0.page", 32'(bus.save_page), 32'd0);
    chk("save0.nobypass", 32'(bus.rd_data), 32'hAA);
    step("rd3a", 0, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("rd3a.const", 32'(bus.rd_data), 32'h55);
    step("rest0", 0, 0, 0, 3, 0, 1, 0, 0, 0);
    step("rd3b", 0, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("rd3b.const", 32'(bus.rd_data), 32'hAA);
    chk("rd3b.free", 32'(bus.pages_free), 32'd8);

    // Fill every page while entry 9 changes each cycle.
    for (int i = 0; i < PAGES; i++) begin
      step("fill", 1, 9, 8'h40 + i, 0, 1, 0, 0, 0, 0);
      chk("fill.page", 32'(bus.save_page), 32'(i));
    end
    chk("fill.full", 32'(bus.pages_full), 32'd1);
    step("save9", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("save9.ack", 32'(bus.save_ack), 32'd0);
    chk("save9.err", 32'(bus.err), 32'd1);
    // Page freed this cycle is not yet allocatable.
    step("relsave", 0, 0, 0, 0, 1, 0, 0, 1, 2);
    chk("relsave.ack", 32'(bus.save_ack), 32'd0);
    step("resave", 0, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("resave.page", 32'(bus.save_page), 32'd2);

    // Restore wins over save; the same-cycle write is dropped.
    step("simul", 1, 9, 8'h11, 0, 1, 1, 1, 0, 0);
    chk("simul.ack", 32'(bus.save_ack), 32'd0);
    chk("simul.err", 32'(bus.err), 32'd0);
    step("rd9", 0, 0, 0, 9, 0, 0, 0, 0, 0);
    chk("rd9.const", 32'(bus.rd_data), 32'h40);
    step("restrel3", 0, 0, 0, 0, 0, 1, 3, 1, 3);
    chk("restrel3.err", 32'(bus.err), 32'd0);
    chk("restrel3.free", 32'(bus.pages_free), 32'd2);

    // Operations on free pages.
    step("restfree", 1, 4, 8'h77, 0, 0, 1, 1, 0, 0);
    chk("restfree.err", 32'(bus.err), 32'd1);
    step("rd4", 0, 0, 0, 4, 0, 0, 0, 0, 0);
    chk("rd4.const", 32'(bus.rd_data), 32'h77);
    step("rd9b", 0, 0, 0, 9, 0, 1'b0, 0, 0, 0);
    step("relfree", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("relfree.err", 32'(bus.err), 32'd1);
    chk("relfree.free", 32'(bus.pages_free), 32'd2);
    step("quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("quiet.err", 32'(bus.err), 32'd0);

    // Reset lands while a save acknowledge is due.
    step("wr5", 1, 5, 8'hEE, 0, 0, 0, 0, 0, 0);
    bus.save_req = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.save_req = 1'b0;
    #1;
    chk("midrst.ack", 32'(bus.save_ack), 32'd0);
    chk("midrst.free", 32'(bus.pages_free), 32'd8);
    chk("midrst.full", 32'(bus.pages_full), 32'd0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step("post5", 0, 0, 0, 5, 0, 0, 0, 0, 0);
    chk("post5.const", 32'(bus.rd_data), 32'd37);
    chk("post5.ack", 32'(bus.save_ack), 32'd0);
    step("postsave", 0, 0, 0, 3, 1, 0, 0, 0, 0);
    chk("postsave.page", 32'(bus.save_page), 32'd0);
    chk("postsave.rd3", 32'(bus.rd_data), 32'd35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rat_ckpt_table.md
RAT_CKPT_TABLE -- requirements
Module: rat_ckpt_table

Interface
REQ-001 SHALL have parameter DATA_W, default 8, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, number of live entries (power of two, >=2).
REQ-003 SHALL have parameter PAGES, default 8, number of checkpoint pages (power of two, >=2).
REQ-004 SHALL have parameter RESET_BASE, default 32, reset value offset for entries.
REQ-005 SHALL define derived AW = clog2(DEPTH) and PW = clog2(PAGES).
REQ-006 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports wr_en in 1, wr_addr in AW, wr_data in DATA_W: live-table write port.
REQ-009 SHALL have ports rd_addr in AW, rd_data out DATA_W: registered live-table read.
REQ-010 SHALL have ports save_req in 1, save_ack out 1, save_page out PW: checkpoint request and allocated page.
REQ-011 SHALL have ports restore_req in 1, restore_page in PW: restore live table from a page.
REQ-012 SHALL have ports release_req in 1, release_page in PW: free a page without restoring.
REQ-013 SHALL have ports pages_full out 1, pages_free out PW+1, err out 1: occupancy status and error pulse.

Function
REQ-014 SHALL write wr_data to entry wr_addr at the clock edge when wr_en=1, unless a restore is accepted that cycle.
REQ-015 SHALL return rd_data one cycle after rd_addr, reading the live table as it was at the start of the request cycle (no write bypass).
REQ-016 SHALL keep a free bitmap of PAGES bits; page valid = not free.
REQ-017 SHALL accept save_req when restore_req=0 and at least one page is free, allocating the lowest-index free page.
REQ-018 SHALL snapshot all DEPTH entries as they were at the start of the save cycle (excluding that cycle's write) into the allocated page.
REQ-019 SHALL pulse save_ack=1 with save_page valid for exactly one cycle, in the cycle after acceptance.
REQ-020 SHALL drive save_ack=0 and pulse err for one cycle after a save_req rejected for no free page, with no state change.
REQ-021 SHALL, on restore_req to a valid page, load all live entries from that page at the edge (visible to reads from the next cycle) and free that page.
REQ-022 SHALL ignore restore_req to a free page, pulse err the following cycle, and still apply that cycle's write.
REQ-023 SHALL give restore priority over save: on simultaneous restore_req and save_req, the save is rejected (save_ack=0, no err).
REQ-024 SHALL free release_page at the edge when release_req=1 and the page is valid; on a free page, ignore and pulse err.
REQ-025 SHALL not let a page freed by release or restore in cycle N be allocated before cycle N+1.
REQ-026 SHALL treat release and restore of the same page in one cycle as a single restore with no err.
REQ-027 SHALL drive pages_free = count of free pages and pages_full = (pages_free==0), both registered and consistent with the bitmap after each edge.
REQ-028 SHALL accept at most one save, one restore and one release per cycle.

Reset
REQ-029 SHALL, while reset=0, asynchronously set live entry i to (RESET_BASE+i) mod 2^DATA_W.
REQ-030 SHALL, while reset=0, mark all pages free, clear save_ack, save_page, err and rd_data to 0, and set pages_free=PAGES, pages_full=0.
REQ-031 SHALL leave page contents undefined after reset; they are never observable before a save.
REQ-032 SHALL abandon any in-flight save or restore on reset assertion, with no ack issued after release.

Structure
REQ-033 SHALL place default parameter constants and a page-id width helper in shared package rat_ckpt_pkg.
REQ-034 SHALL implement free-bitmap, lowest-free priority encode and popcount in sub-module rat_ckpt_page_alloc.
REQ-035 SHALL hold page storage as a PAGES x DEPTH x DATA_W register array inside rat_ckpt_table.

Verification (DATA_W=8, DEPTH=128, PAGES=8, RESET_BASE=32)
REQ-036 SHALL check reset: release reset, rd_addr=5 -> rd_data=37 next cycle; rd_addr=127 -> 159; pages_free=8.
REQ-037 SHALL check save/write/restore: write entry 3=0xAA, save -> save_ack, save_page=0; same cycle as save write entry 3=0x55; restore page 0 -> entry 3 reads 0xAA, pages_free=8.
REQ-038 SHALL check full: 8 saves -> pages 0..7, pages_full=1; 9th save -> save_ack=0, err pulse; release page 2 -> next save gets page 2.
REQ-039 SHALL check simultaneous requests: restore page 1 + save + write entry 9=0x11 same cycle -> save not acked, no err, entry 9 equals page-1 value.
REQ-040 SHALL check errors: restore or release of a free page -> err pulse, table unchanged except that cycle's write.
REQ-041 SHALL check mid-operation reset: reset asserted the cycle after save_req -> no save_ack, pages_free=8, entries at reset values.
